// File: rtl/apb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_ctrl (with helper apb_uart_ctrl_fifo)
// Brief    : APB3 register front-end for the UART core. It holds a TX FIFO
//            with a launcher FSM, an RX capture FIFO, the frame
//            configuration register and sticky error status.
// Revision : 1.0 - initial release
// ============================================================================

// Small synchronous byte FIFO. A pop on an empty FIFO is ignored. A push
// on a full FIFO is accepted only when a pop happens in the same cycle.
module apb_uart_ctrl_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] c_FULL_COUNT = (PW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign w_pop_ok  = i_pop & (r_count != '0);
  assign w_push_ok = i_push & ((r_count != c_FULL_COUNT) | w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_full    = (r_count == c_FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

  // Storage array; contents need no reset because the count gates them.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module apb_uart_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [4:0] CFG_RESET  = 5'b00011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  tx_data_out,
  output logic        start_tx_out,
  input  logic        tx_busy_in,
  input  logic        tx_done_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_done_in,
  input  logic        parity_error_in,
  output logic [4:0]  cfg_reg_out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LAUNCH = 2'd1;
  localparam logic [1:0] c_WAIT   = 2'd2;

  localparam logic [1:0] c_A_TXDATA = 2'd0;
  localparam logic [1:0] c_A_RXDATA = 2'd1;
  localparam logic [1:0] c_A_CFG    = 2'd2;
  localparam logic [1:0] c_A_STATUS = 2'd3;

  logic [1:0]    r_state;
  logic [7:0]    r_tx_data;
  logic [4:0]    r_cfg;
  logic          r_overrun;
  logic          r_parity;

  logic          w_rd;
  logic          w_wr;
  logic [1:0]    w_addr;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_rx_pop_req;
  logic          w_rx_pop;
  logic          w_sts_wr;
  logic [7:0]    w_tx_head;
  logic [7:0]    w_rx_head;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_tx_count;
  logic [CW-1:0] w_rx_count;
  logic [3:0]    w_tx_cnt4;
  logic [3:0]    w_rx_cnt4;
  logic [31:0]   w_status;
  logic          w_unused_ok;

  assign w_addr       = paddr[3:2];
  assign w_rd         = psel & penable & ~pwrite;
  assign w_wr         = psel & penable & pwrite;
  assign w_tx_push    = w_wr & (w_addr == c_A_TXDATA);
  assign w_tx_pop     = (r_state == c_IDLE) & ~w_tx_empty & ~tx_busy_in;
  assign w_rx_pop_req = w_rd & (w_addr == c_A_RXDATA);
  assign w_rx_pop     = w_rx_pop_req & ~w_rx_empty;
  assign w_sts_wr     = w_wr & (w_addr == c_A_STATUS);
  assign w_tx_cnt4    = 4'(w_tx_count);
  assign w_rx_cnt4    = 4'(w_rx_count);
  assign w_unused_ok  = &{1'b0, paddr[1:0], pwdata[31:8]};

  assign pready       = 1'b1;
  assign start_tx_out = (r_state == c_LAUNCH);
  assign tx_data_out  = r_tx_data;
  assign cfg_reg_out  = r_cfg;

  assign w_status = {16'b0, w_rx_cnt4, w_tx_cnt4, 1'b0, r_parity, r_overrun,
                     (r_state != c_IDLE), w_rx_empty, w_rx_full,
                     w_tx_empty, w_tx_full};

  apb_uart_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_data  (pwdata[7:0]),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  apb_uart_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (rx_done_in),
    .i_data  (rx_data_in),
    .i_pop   (w_rx_pop),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  // Read mux and error response; both are live only in the access phase.
  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (w_tx_push && w_tx_full && !w_tx_pop) pslverr = 1'b1;
    if (w_rx_pop_req && w_rx_empty)          pslverr = 1'b1;
    if (w_rd) begin
      case (w_addr)
        c_A_RXDATA: prdata = w_rx_empty ? 32'd0 : {24'b0, w_rx_head};
        c_A_CFG:    prdata = {27'b0, r_cfg};
        c_A_STATUS: prdata = w_status;
        default:    prdata = '0;
      endcase
    end
  end

  // TX launcher: pop and latch the head, pulse start for one cycle, then
  // hold off until the core reports the frame is done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_tx_data <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_tx_pop) begin
            r_tx_data <= w_tx_head;
            r_state   <= c_LAUNCH;
          end
        end
        c_LAUNCH: r_state <= c_WAIT;
        c_WAIT:   if (tx_done_in) r_state <= c_IDLE;
        default:  r_state <= c_IDLE;
      endcase
    end
  end

  // CFG register and sticky status; a new event wins over a W1C clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg     <= CFG_RESET;
      r_overrun <= 1'b0;
      r_parity  <= 1'b0;
    end else begin
      if (w_wr && (w_addr == c_A_CFG)) r_cfg <= pwdata[4:0];
      if (rx_done_in && w_rx_full && !w_rx_pop) r_overrun <= 1'b1;
      else if (w_sts_wr && pwdata[5])           r_overrun <= 1'b0;
      if (rx_done_in && parity_error_in)        r_parity  <= 1'b1;
      else if (w_sts_wr && pwdata[6])           r_parity  <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: doc/apb_uart_ctrl.md
# apb_uart_ctrl

APB3 slave register front-end for `uart_top`, directly upstream of the UART core. Buffers CPU writes in a TX FIFO and launches bytes into the core via `start_tx_in`/`tx_data_in`. Captures received bytes from `rx_done_out`/`rx_data_out` into an RX FIFO. Drives the core's 5-bit frame configuration and records sticky error status.

## Interface
- `FIFO_DEPTH`, default 4: entries per FIFO. Must be a power of 2 in the range 2..8.
- `CFG_RESET`, default 5'b00011: reset value of CFG (8-N-1).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `psel`, `penable`, `pwrite` in 1 each: APB3 control.
- `paddr` in 4: byte address. `paddr[1:0]` is ignored.
- `pwdata` in 32: write data.
- `prdata` out 32: read data.
- `pready` out 1: constant 1 (zero wait states).
- `pslverr` out 1: error response.
- `tx_data_out` out 8: connects to core `tx_data_in`.
- `start_tx_out` out 1: connects to core `start_tx_in`.
- `tx_busy_in`, `tx_done_in` in 1 each: from core.
- `rx_data_in` in 8: from core `rx_data_out`.
- `rx_done_in` in 1: from core.
- `parity_error_in` in 1: from core.
- `cfg_reg_out` out 5: connects to core `cfg_reg_in`.

## Operation
- Access phase is `psel & penable`. Writes and pops take effect on the rising edge that ends the access phase.
- Register map by `paddr[3:2]`:
  - 0 TXDATA: write pushes `pwdata[7:0]`. Read returns 0.
  - 1 RXDATA: read returns `{24'b0, head}` and pops. Write is ignored.
  - 2 CFG: read/write `[4:0]`.
  - 3 STATUS: read only, except W1C on bits 5 and 6.
- STATUS bits:
  - [0] tx_full
  - [1] tx_empty
  - [2] rx_full
  - [3] rx_empty
  - [4] tx_active (FSM not IDLE)
  - [5] rx_overrun (sticky)
  - [6] parity_err (sticky)
  - [11:8] tx_count
  - [15:12] rx_count
  - all other bits 0
- `pslverr` is combinational, asserted in the access phase only, in two cases:
  - TXDATA write while the TX FIFO is full and not popping that cycle. The data is dropped.
  - RXDATA read while the RX FIFO is empty. `prdata` is 0 and no pop occurs.
- `prdata` is 0 outside read access phases.
- Simultaneous push and pop on a full FIFO: the pop frees space first, so the push is accepted. Simultaneous push and pop on an empty FIFO: the pop is rejected and the push is accepted.
- Pointers wrap modulo `FIFO_DEPTH`. Counts run 0..`FIFO_DEPTH`.
- TX launcher FSM:
  - IDLE → LAUNCH when the TX FIFO is non-empty and `tx_busy_in`=0. The FIFO head pops and latches into `tx_data_out`.
  - LAUNCH: `start_tx_out`=1 for exactly one cycle, then → WAIT.
  - WAIT → IDLE on the cycle `tx_done_in`=1 is sampled.
  - `tx_data_out` holds its value until the next launch.
- RX capture, on each cycle `rx_done_in`=1 is sampled:
  - If there is space (counting a same-cycle pop), push `rx_data_in`. Otherwise drop it and set rx_overrun.
  - If `parity_error_in`=1 in the same cycle, set parity_err. The byte is still pushed.
- Sticky bits: W1C clears them. A set and a clear in the same cycle resolves to set.

## Timing
- Reset values:
  - `prdata`=0, `pslverr`=0, `pready`=1.
  - `tx_data_out`=0, `start_tx_out`=0.
  - `cfg_reg_out`=`CFG_RESET`.
  - Both FIFOs empty, stickies 0, FSM in IDLE.
- Reset mid-frame: the FSM returns to IDLE and FIFO contents are discarded. The core shares `rst_n`.
- TXDATA write completing at edge k, with the FSM in IDLE and the core idle:
  - `start_tx_out`=1 from edge k+1 to edge k+2.
  - `tx_data_out` is valid from edge k+1.
- Back-to-back launches: the next LAUNCH starts no earlier than one edge after WAIT exits, and only while `tx_busy_in`=0.
- `rx_done_in` sampled at edge k → rx_empty=0 and RXDATA is readable from edge k onward (the next cycle).
- CFG write at edge k → `cfg_reg_out` updates at edge k. Software is responsible for writing CFG only while the core is idle.

## Test plan
- Reset: read CFG → 0x03. Read STATUS → 0x000A (tx_empty, rx_empty). `start_tx_out`=0.
- Loopback (core `txd_out` tied to `rxd_in`): write TXDATA 0x55. Then `start_tx_out` pulses once with `tx_data_out`=0x55, rx_count becomes 1, and an RXDATA read returns 0x55 with `pslverr`=0.
- TX overflow: hold `tx_busy_in`=1 and write 5 bytes with `FIFO_DEPTH`=4. Writes 1-4 have `pslverr`=0; write 5 has `pslverr`=1. After releasing busy, exactly 4 launches occur in write order.
- RX overrun: inject 5 `rx_done_in` pulses (0xA0..0xA4) with no reads. STATUS[5]=1, and reads return 0xA0..0xA3. A 5th read gives `pslverr`=1 and `prdata`=0. Writing 0x20 to STATUS clears bit 5.
- Parity: a `rx_done_in` pulse with `parity_error_in`=1 and data 0x3C sets STATUS[6]. RXDATA still returns 0x3C. A W1C in the same cycle as a new parity error leaves bit 6 set.
- Full RX FIFO with an RXDATA read in the same cycle as `rx_done_in`: the new byte is accepted and rx_overrun stays 0.
